ncc_array: RTL and testbench



---
 rtl/ncc_array.sv | 163 ++++++++++++++++
 tb/tb_ncc_array.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncc_array.sv
//----------------------------------------------------------------------------
// ncc_array - log2-domain NCC multiply-accumulate array, transposed form.
// Optional NCC_ARRAY_SATURATE_EN: saturating accumulator adds.  Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module ncc_array #(
  parameter int NUM_TAPS = 16,
  parameter int INT_W    = 5,
  parameter int FRAC_W   = 27,
  parameter int ACC_W    = 16,
  parameter int DATA_W   = 1 + INT_W + FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [DATA_W-1:0] desc_data,
  output logic              desc_loaded,
  input  logic              start,
  input  logic              win_valid,
  output logic              win_ready,
  input  logic [DATA_W-1:0] win_data,
  input  logic              win_last,
  output logic              score_valid,
  input  logic              score_ready,
  output logic [ACC_W-1:0]  score,
  output logic              busy
);

  localparam int MAG_W = INT_W + FRAC_W;
  localparam int CNT_W = $clog2(NUM_TAPS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_TAPS);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
`ifdef NCC_ARRAY_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]        state, state_nx;
  logic [DATA_W-1:0] coef [NUM_TAPS];
  logic [ACC_W-1:0]  acc  [1:NUM_TAPS-1];
  logic [ACC_W-1:0]  term [NUM_TAPS];
  logic [CNT_W-1:0]  load_cnt, fill_cnt;
  logic              desc_acc, advance, fill_ok, flush_done, short_last, clear;

  // Mitchell antilog of the summed log magnitudes: (1.frac << I) truncated to an integer.
  function automatic logic [ACC_W-1:0] pe_term(input logic [DATA_W-1:0] c,
                                               input logic [DATA_W-1:0] x);
    logic [MAG_W:0]          l;
    logic [INT_W:0]          i;
    logic [FRAC_W+ACC_W-1:0] ext;
    logic [ACC_W-1:0]        p;
    l   = {1'b0, c[MAG_W-1:0]} + {1'b0, x[MAG_W-1:0]};
    i   = l[MAG_W:FRAC_W];
    ext = {{(ACC_W-1){1'b0}}, 1'b1, l[FRAC_W-1:0]} << i;
    if (int'(i) >= ACC_W - 1) p = ACC_MAX;
    else                      p = ACC_W'(ext >> FRAC_W);
    return (c[DATA_W-1] ^ x[DATA_W-1]) ? -p : p;
  endfunction

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
`ifdef NCC_ARRAY_SATURATE_EN
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
`else
    return a + b;
`endif
  endfunction

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_cell
    assign term[k] = pe_term(coef[k], win_data);
  end

  assign desc_acc   = desc_valid && desc_ready;
  assign advance    = win_valid && win_ready;
  assign fill_ok    = (fill_cnt >= CNT_LAST);
  assign short_last = advance && win_last && !fill_ok;
  assign flush_done = (state == S_FLUSH) && (!score_valid || score_ready);
  assign clear      = flush_done || short_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (desc_valid)                state_nx = S_LOAD;
        else if (start && desc_loaded) state_nx = S_RUN;
      end
      S_LOAD:  if (desc_acc && load_cnt == CNT_LAST) state_nx = S_IDLE;
      S_RUN:   if (advance && win_last) state_nx = fill_ok ? S_FLUSH : S_IDLE;
      S_FLUSH: if (flush_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    desc_ready = 1'b0;
    win_ready  = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE, S_LOAD: desc_ready = 1'b1;
      S_RUN:          win_ready  = !score_valid || score_ready;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) coef[k] <= '0;
      for (int k = 1; k < NUM_TAPS; k++) acc[k] <= '0;
      load_cnt    <= '0;
      fill_cnt    <= '0;
      score       <= '0;
      score_valid <= 1'b0;
      desc_loaded <= 1'b0;
    end else begin
      // New words enter at the top tap so the first word ends at tap 0.
      if (desc_acc) begin
        for (int k = 0; k < NUM_TAPS - 1; k++) coef[k] <= coef[k+1];
        coef[NUM_TAPS-1] <= desc_data;
        if (state == S_IDLE) begin
          load_cnt    <= CNT_W'(1);
          desc_loaded <= 1'b0;
        end else if (load_cnt == CNT_LAST) begin
          load_cnt    <= '0;
          desc_loaded <= 1'b1;
        end else begin
          load_cnt <= load_cnt + 1'b1;
        end
      end

      if (clear) begin
        for (int k = 1; k < NUM_TAPS; k++) acc[k] <= '0;
        fill_cnt <= '0;
      end else if (advance) begin
        acc[NUM_TAPS-1] <= term[NUM_TAPS-1];
        for (int k = 1; k < NUM_TAPS - 1; k++) acc[k] <= acc_add(acc[k+1], term[k]);
        if (fill_cnt != CNT_FULL) fill_cnt <= fill_cnt + 1'b1;
      end

      if (advance) score <= acc_add(acc[1], term[0]);

      if (advance && fill_ok) score_valid <= 1'b1;
      else if (score_ready)   score_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ncc_array.sv
//----------------------------------------------------------------------------
// tb_ncc_array - randomized self-checking bench for ncc_array.  Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_ncc_array;

  localparam int N      = 16;
  localparam int INT_W  = 5;
  localparam int FRAC_W = 27;
  localparam int ACC_W  = 16;
  localparam int DATA_W = 1 + INT_W + FRAC_W;
  localparam int MAG_W  = INT_W + FRAC_W;

  logic              clk, rst_n;
  logic              desc_valid, desc_ready, desc_loaded;
  logic [DATA_W-1:0] desc_data;
  logic              start, win_valid, win_ready, win_last;
  logic [DATA_W-1:0] win_data;
  logic              score_valid, score_ready, busy;
  logic [ACC_W-1:0]  score;

  ncc_array #(.NUM_TAPS(N), .INT_W(INT_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
    .desc_loaded(desc_loaded), .start(start),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data), .win_last(win_last),
    .score_valid(score_valid), .score_ready(score_ready), .score(score), .busy(busy)
  );

  always #5 clk = ~clk;

  int passed, total;
  logic [DATA_W-1:0] desc_m [N];
  logic [DATA_W-1:0] pix_q [$];
  logic [DATA_W-1:0] hist [$];
  int obs_q [$];
  int exp_q [$];
  int last_acc_cyc, first_sv_cyc, bp_viol;
  bit loaded_drop, timeout;

  function automatic logic [DATA_W-1:0] mk(input bit s, input int i, input longint f);
    logic [INT_W-1:0]  iv;
    logic [FRAC_W-1:0] fv;
    iv = i[INT_W-1:0];
    fv = f[FRAC_W-1:0];
    return {s, iv, fv};
  endfunction

  function automatic logic [DATA_W-1:0] rnd_word();
    return mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), longint'($urandom));
  endfunction

  // Reference term: floor(2^L) with 2^frac approximated as (1 + frac).
  function automatic longint term_ref(input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] x);
    longint l, i, f, p;
    l = longint'(c[MAG_W-1:0]) + longint'(x[MAG_W-1:0]);
    i = l >> FRAC_W;
    f = l & ((longint'(1) << FRAC_W) - 1);
    if (i >= ACC_W - 1) p = (longint'(1) << (ACC_W - 1)) - 1;
    else                p = (((longint'(1) << FRAC_W) + f) << i) >> FRAC_W;
    return (c[DATA_W-1] ^ x[DATA_W-1]) ? -p : p;
  endfunction

  function automatic longint fold_ref(input longint a, input longint b);
`ifdef NCC_ARRAY_SATURATE_EN
    longint s;
    s = a + b;
    if (s > (longint'(1) << (ACC_W - 1)) - 1) s = (longint'(1) << (ACC_W - 1)) - 1;
    if (s < -(longint'(1) << (ACC_W - 1)))    s = -(longint'(1) << (ACC_W - 1));
    return s;
`else
    logic [63:0]      u;
    logic [ACC_W-1:0] w;
    u = a + b;
    w = u[ACC_W-1:0];
    return longint'($signed(w));
`endif
  endfunction

  task automatic send_desc(input int n);
    for (int k = 0; k < n; k++) begin
      desc_valid = 1'b1;
      desc_data  = desc_m[k];
      @(posedge clk); #1;
    end
    desc_valid = 1'b0;
  endtask

  // Runs one window: start pulse, stream pix_q, collect scores, model expected scores.
  task automatic stream(input int hold, input bit rnd);
    int n, idx, hold_left;
    bit held, done, acc, stalled_prev;
    logic [ACC_W-1:0] prev;
    longint s;
    n = pix_q.size(); idx = 0; hold_left = 0; held = 0; done = 0; stalled_prev = 0; prev = '0;
    obs_q.delete(); exp_q.delete(); hist.delete();
    last_acc_cyc = -1; first_sv_cyc = -1; bp_viol = 0; loaded_drop = 0; timeout = 0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      win_valid = (idx < n) && (!rnd || $urandom_range(0, 3) != 0);
      win_data  = (idx < n) ? pix_q[idx] : '0;
      win_last  = (idx == n - 1);
      if (hold > 0 && score_valid && !held) begin held = 1; hold_left = hold; end
      if (hold_left > 0) begin score_ready = 1'b0; hold_left--; end
      else score_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (score_valid && first_sv_cyc < 0) first_sv_cyc = cyc;
      if (!desc_loaded) loaded_drop = 1;
      if (score_valid && !score_ready && win_ready) bp_viol++;
      if (score_valid && stalled_prev && score !== prev) bp_viol++;
      stalled_prev = score_valid && !score_ready;
      prev = score;
      acc = win_valid && win_ready;
      if (acc) begin
        hist.push_back(pix_q[idx]);
        if (idx == n - 1) last_acc_cyc = cyc;
        if (hist.size() >= N) begin
          s = 0;
          for (int k = N - 1; k >= 0; k--)
            s = fold_ref(s, term_ref(desc_m[k], hist[hist.size() - 1 - k]));
          exp_q.push_back(int'(s));
        end
      end
      if (score_valid && score_ready) obs_q.push_back(int'($signed(score)));
      @(posedge clk); #1;
      if (acc) idx++;
      if (idx == n && !busy && !score_valid) done = 1;
    end
    if (!done) timeout = 1;
    win_valid = 1'b0; win_last = 1'b0; score_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if ({desc_loaded, score_valid, busy, win_ready} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {desc_loaded, score_valid, busy, win_ready}); else passed++;
    total++; if (score !== '0) $display("FAIL reset_score got %0d want 0", score); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (desc_ready !== 1'b1) $display("FAIL idle_desc_ready got %b want 1", desc_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_basic();
    for (int k = 0; k < N; k++) desc_m[k] = mk(0, 1, 0);
    send_desc(N);
    total++; if (desc_loaded !== 1'b1) $display("FAIL basic_loaded got %b want 1", desc_loaded); else passed++;
    pix_q.delete();
    for (int k = 0; k < N; k++) pix_q.push_back(mk(0, 2, 0));
    stream(0, 0);
    total++; if (timeout) $display("FAIL basic_timeout got 1 want 0"); else passed++;
    total++; if (obs_q.size() !== 1) $display("FAIL basic_count got %0d want 1", obs_q.size()); else passed++;
    total++; if (obs_q.size() > 0 && obs_q[0] !== 128) $display("FAIL basic_score got %0d want 128", obs_q[0]); else passed++;
    total++; if (first_sv_cyc !== last_acc_cyc + 1) $display("FAIL basic_latency got %0d want %0d", first_sv_cyc, last_acc_cyc + 1); else passed++;
    total++; if (loaded_drop) $display("FAIL basic_loaded_kept got 0 want 1"); else passed++;
    total++; if (busy !== 1'b0 || desc_loaded !== 1'b1) $display("FAIL basic_idle got busy=%b loaded=%b want 0/1", busy, desc_loaded); else passed++;
  endtask

  task automatic test_alternating();
    for (int k = 0; k < N; k++) desc_m[k] = mk(k % 2, 1, 0);
    send_desc(N);
    pix_q.delete();
    for (int k = 0; k < 20; k++) pix_q.push_back(mk(0, 2, 0));
    stream(0, 0);
    total++; if (obs_q.size() !== 5) $display("FAIL alt_count got %0d want 5", obs_q.size()); else passed++;
    foreach (obs_q[i]) begin
      total++; if (obs_q[i] !== 0) $display("FAIL alt_score[%0d] got %0d want 0", i, obs_q[i]); else passed++;
    end
  endtask

  task automatic test_mitchell();
    // Taps 1..12 cancel in pairs, 13 and 14 give +1 each, tap 15 gives -2.
    desc_m[0] = mk(0, 3, longint'(1) << (FRAC_W - 1));
    for (int k = 1; k <= 12; k++) desc_m[k] = mk(k % 2 == 0, 0, 0);
    desc_m[13] = mk(0, 0, 0);
    desc_m[14] = mk(0, 0, 0);
    desc_m[15] = mk(1, 1, 0);
    send_desc(N);
    pix_q.delete();
    for (int k = 0; k < N; k++) pix_q.push_back(mk(0, 0, 0));
    stream(0, 0);
    total++; if (obs_q.size() !== 1 || obs_q[0] !== 12) $display("FAIL mitchell_score got n=%0d v=%0d want 12", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : -1); else passed++;
  endtask

  task automatic test_overflow();
    int want;
`ifdef NCC_ARRAY_SATURATE_EN
    want = 32767;
`else
    want = 0;
`endif
    for (int k = 0; k < N; k++) desc_m[k] = mk(0, 7, 0);
    send_desc(N);
    pix_q.delete();
    for (int k = 0; k < N; k++) pix_q.push_back(mk(0, 7, 0));
    stream(0, 0);
    total++; if (obs_q.size() !== 1 || obs_q[0] !== want) $display("FAIL overflow_score got n=%0d v=%0d want %0d", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : -1, want); else passed++;
  endtask

  task automatic test_short_run();
    pix_q.delete();
    for (int k = 0; k < 5; k++) pix_q.push_back(rnd_word());
    stream(0, 0);
    total++; if (obs_q.size() !== 0 || timeout) $display("FAIL short_run got n=%0d timeout=%0d want 0/0", obs_q.size(), timeout); else passed++;
    total++; if (busy !== 1'b0 || desc_loaded !== 1'b1) $display("FAIL short_idle got busy=%b loaded=%b want 0/1", busy, desc_loaded); else passed++;
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < N; k++) desc_m[k] = rnd_word();
    send_desc(N);
    pix_q.delete();
    for (int k = 0; k < 24; k++) pix_q.push_back(rnd_word());
    stream(5, 0);
    total++; if (bp_viol !== 0) $display("FAIL bp_stall got %0d violations want 0", bp_viol); else passed++;
    total++; if (obs_q.size() !== 9 || exp_q.size() !== 9) $display("FAIL bp_count got %0d want 9", obs_q.size()); else passed++;
    foreach (exp_q[i]) begin
      total++; if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) $display("FAIL bp_score[%0d] got %0d want %0d", i, i < obs_q.size() ? obs_q[i] : -1, exp_q[i]); else passed++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) desc_m[k] = rnd_word();
      send_desc(N);
      pix_q.delete();
      for (int k = 0; k < 30; k++) pix_q.push_back(rnd_word());
      stream(0, 1);
      total++; if (obs_q.size() !== exp_q.size() || timeout) $display("FAIL rnd%0d_count got %0d want %0d", r, obs_q.size(), exp_q.size()); else passed++;
      total++; if (bp_viol !== 0) $display("FAIL rnd%0d_stall got %0d violations want 0", r, bp_viol); else passed++;
      foreach (exp_q[i]) begin
        total++; if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) $display("FAIL rnd%0d_score[%0d] got %0d want %0d", r, i, i < obs_q.size() ? obs_q[i] : -1, exp_q[i]); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_load();
    for (int k = 0; k < N; k++) desc_m[k] = rnd_word();
    send_desc(7);
    rst_n = 1'b0;
    #2;
    total++; if ({desc_loaded, score_valid, busy, win_ready} !== 4'b0 || score !== '0) $display("FAIL midload_reset got flags=%b score=%0d want 0", {desc_loaded, score_valid, busy, win_ready}, score); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || desc_loaded !== 1'b0) $display("FAIL midload_start_ignored got busy=%b loaded=%b want 0/0", busy, desc_loaded); else passed++;
    send_desc(N);
    pix_q.delete();
    for (int k = 0; k < N; k++) pix_q.push_back(rnd_word());
    stream(0, 0);
    total++; if (obs_q.size() !== 1 || exp_q.size() !== 1 || obs_q[0] !== exp_q[0]) $display("FAIL midload_reload got n=%0d v=%0d want %0d", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : -1, exp_q.size() > 0 ? exp_q[0] : -1); else passed++;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    desc_valid = 1'b0; desc_data = '0; start = 1'b0;
    win_valid = 1'b0; win_data = '0; win_last = 1'b0; score_ready = 1'b1;
    passed = 0; total = 0;
    test_reset();
    test_basic();
    test_alternating();
    test_mitchell();
    test_overflow();
    test_short_run();
    test_backpressure();
    test_random();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
